sound_mixer: RTL and testbench

- Downstream stage for the four channel generators: the two square-wave channels, the waveform channel and the noise channel.
- Once per audio sample strobe, it does three things:
  - snapshots the four 4-bit channel levels;
  - routes each channel to the left and/or right bus per NR51;
  - scales each bus by the NR50 master volume.
- Presents one signed stereo sample pair to the AC97 output stage over a valid/ready handshake.

---
 rtl/sound_mixer.sv | 189 ++++++++++++++++++
 tb/tb_sound_mixer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sound_mixer.sv
// Stereo mixer: snapshots four 4-bit channel levels per sample strobe, routes them
// onto left/right buses, applies master volume and DC removal, and hands off via valid/ready.
module sound_mixer #(
    parameter int SAMPLE_W   = 20,
    parameter int DC_OFFSET  = 240,
    parameter int GAIN_SHIFT = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_strobe,
    input  logic [3:0]          ch1_level,
    input  logic [3:0]          ch2_level,
    input  logic [3:0]          ch3_level,
    input  logic [3:0]          ch4_level,
    input  logic [7:0]          nr50,
    input  logic [7:0]          nr51,
    input  logic                sound_on,
    output logic [SAMPLE_W-1:0] sample_left,
    output logic [SAMPLE_W-1:0] sample_right,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                busy,
    output logic [7:0]          overrun_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCALE = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic [SAMPLE_W-1:0] DC_OFF_W = SAMPLE_W'(DC_OFFSET);

    // Bus scaling: acc * (vol + 1) fits 9 bits (60 * 8 = 480), then offset removal and gain.
    function automatic logic [SAMPLE_W-1:0] scale_bus(input logic [5:0] acc, input logic [2:0] vol);
        logic [8:0]          scaled;
        logic [SAMPLE_W-1:0] centred;
        scaled  = {3'b000, acc} * {6'b000000, vol} + {3'b000, acc};
        centred = {{(SAMPLE_W-9){1'b0}}, scaled} - DC_OFF_W;
        return centred << GAIN_SHIFT;
    endfunction

    state_t                state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [3:0][3:0]       lvl_q, lvl_d;
    logic [7:0]            nr50_q, nr50_d;
    logic [7:0]            nr51_q, nr51_d;
    logic                  on_q, on_d;
    logic [5:0]            acc_l_q, acc_l_d;
    logic [5:0]            acc_r_q, acc_r_d;
    logic [SAMPLE_W-1:0]   left_q, left_d;
    logic [SAMPLE_W-1:0]   right_q, right_d;
    logic                  valid_q, valid_d;
    logic [7:0]            ovr_q, ovr_d;
    logic                  accept_s;
    logic                  drop_s;
    logic [3:0]            lvl_sel_s;

    // Next-state, accumulation, scaling and overrun logic.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        lvl_d     = lvl_q;
        nr50_d    = nr50_q;
        nr51_d    = nr51_q;
        on_d      = on_q;
        acc_l_d   = acc_l_q;
        acc_r_d   = acc_r_q;
        left_d    = left_q;
        right_d   = right_q;
        valid_d   = valid_q;
        ovr_d     = ovr_q;
        accept_s  = 1'b0;
        drop_s    = 1'b0;
        lvl_sel_s = lvl_q[idx_q];

        case (state_q)
            IDLE: begin
                if (sample_strobe) begin
                    accept_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                if (nr51_q[3'd4 + {1'b0, idx_q}]) begin
                    acc_l_d = acc_l_q + {2'b00, lvl_sel_s};
                end else begin
                    acc_l_d = acc_l_q;
                end
                if (nr51_q[{1'b0, idx_q}]) begin
                    acc_r_d = acc_r_q + {2'b00, lvl_sel_s};
                end else begin
                    acc_r_d = acc_r_q;
                end
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = SCALE;
                end else begin
                    state_d = ACCUM;
                end
                drop_s = sample_strobe;
            end
            SCALE: begin
                if (on_q) begin
                    left_d  = scale_bus(acc_l_q, nr50_q[6:4]);
                    right_d = scale_bus(acc_r_q, nr50_q[2:0]);
                end else begin
                    left_d  = '0;
                    right_d = '0;
                end
                valid_d = 1'b1;
                state_d = OUT;
                drop_s  = sample_strobe;
            end
            OUT: begin
                if (sample_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                    accept_s = sample_strobe;
                end else begin
                    drop_s = sample_strobe;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        if (accept_s) begin
            lvl_d   = {ch4_level, ch3_level, ch2_level, ch1_level};
            nr50_d  = nr50;
            nr51_d  = nr51;
            on_d    = sound_on;
            acc_l_d = 6'd0;
            acc_r_d = 6'd0;
            idx_d   = 2'd0;
            state_d = ACCUM;
        end else begin
            lvl_d = lvl_d;
        end

        if (drop_s && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 8'd1;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            lvl_q   <= '0;
            nr50_q  <= 8'd0;
            nr51_q  <= 8'd0;
            on_q    <= 1'b0;
            acc_l_q <= 6'd0;
            acc_r_q <= 6'd0;
            left_q  <= '0;
            right_q <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lvl_q   <= lvl_d;
            nr50_q  <= nr50_d;
            nr51_q  <= nr51_d;
            on_q    <= on_d;
            acc_l_q <= acc_l_d;
            acc_r_q <= acc_r_d;
            left_q  <= left_d;
            right_q <= right_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign sample_left   = left_q;
    assign sample_right  = right_q;
    assign sample_valid  = valid_q;
    assign busy          = (state_q != IDLE);
    assign overrun_count = ovr_q;

endmodule

// File: tb/tb_sound_mixer.sv
// Directed bench for sound_mixer: routing, scaling, master enable, backpressure,
// overrun counting, asynchronous reset and saturation, against hand-computed values.
module tb_sound_mixer;

    logic        clk;
    logic        reset;
    logic        sample_strobe;
    logic [3:0]  ch1_level, ch2_level, ch3_level, ch4_level;
    logic [7:0]  nr50, nr51;
    logic        sound_on;
    logic [19:0] sample_left, sample_right;
    logic        sample_valid;
    logic        sample_ready;
    logic        busy;
    logic [7:0]  overrun_count;

    int checks_r = 0;
    int errors_r = 0;

    sound_mixer #(.SAMPLE_W(20), .DC_OFFSET(240), .GAIN_SHIFT(10)) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_strobe (sample_strobe),
        .ch1_level     (ch1_level),
        .ch2_level     (ch2_level),
        .ch3_level     (ch3_level),
        .ch4_level     (ch4_level),
        .nr50          (nr50),
        .nr51          (nr51),
        .sound_on      (sound_on),
        .sample_left   (sample_left),
        .sample_right  (sample_right),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .busy          (busy),
        .overrun_count (overrun_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_inputs(input logic [3:0] l1, l2, l3, l4,
                              input logic [7:0] n50, n51, input logic on);
        ch1_level = l1; ch2_level = l2; ch3_level = l3; ch4_level = l4;
        nr50 = n50; nr51 = n51; sound_on = on;
    endtask

    // Called at the negedge just after the strobe edge E0; ends at the negedge after E5.
    task automatic wait_result(input string tag, input int exp_l, input int exp_r);
        check_eq({tag, "_busy0"}, int'(busy), 1);
        check_eq({tag, "_valid0"}, int'(sample_valid), 0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check_eq({tag, "_lat"}, int'(sample_valid), 0);
        end
        @(negedge clk);
        check_eq({tag, "_valid"}, int'(sample_valid), 1);
        check_eq({tag, "_left"}, int'($signed(sample_left)), exp_l);
        check_eq({tag, "_right"}, int'($signed(sample_right)), exp_r);
    endtask

    task automatic strobe_once();
        sample_strobe = 1'b1;
        @(negedge clk);
        sample_strobe = 1'b0;
    endtask

    task automatic handshake(input string tag, input int exp_l, input int exp_r);
        sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
        check_eq({tag, "_hs_valid"}, int'(sample_valid), 0);
        check_eq({tag, "_hs_busy"}, int'(busy), 0);
        check_eq({tag, "_hs_keep"}, int'($signed(sample_left)), exp_l);
        check_eq({tag, "_hs_keepr"}, int'($signed(sample_right)), exp_r);
    endtask

    initial begin
        reset = 1'b0;
        sample_strobe = 1'b0;
        sample_ready = 1'b0;
        set_inputs(4'd0, 4'd0, 4'd0, 4'd0, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        check_eq("rst_valid", int'(sample_valid), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_left", int'($signed(sample_left)), 0);
        check_eq("rst_ovr", int'(overrun_count), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        set_inputs(4'd15, 4'd0, 4'd0, 4'd0, 8'h77, 8'h11, 1'b1);
        strobe_once();
        set_inputs(4'd0, 4'd0, 4'd0, 4'd0, 8'h00, 8'h00, 1'b0);
        wait_result("route", -122880, -122880);
        handshake("route", -122880, -122880);

        set_inputs(4'd15, 4'd15, 4'd15, 4'd15, 8'h77, 8'hFF, 1'b1);
        strobe_once();
        wait_result("full", 245760, 245760);
        handshake("full", 245760, 245760);

        set_inputs(4'd4, 4'd8, 4'd2, 4'd1, 8'h30, 8'h21, 1'b1);
        strobe_once();
        wait_result("asym", -212992, -241664);
        handshake("asym", -212992, -241664);

        set_inputs(4'd15, 4'd15, 4'd15, 4'd15, 8'h07, 8'h0F, 1'b1);
        strobe_once();
        wait_result("ronly", -245760, 245760);
        handshake("ronly", -245760, 245760);

        set_inputs(4'd15, 4'd15, 4'd15, 4'd15, 8'h77, 8'hFF, 1'b0);
        strobe_once();
        wait_result("off", 0, 0);
        handshake("off", 0, 0);

        // Backpressure with two dropped strobes while the pair is held.
        set_inputs(4'd15, 4'd0, 4'd0, 4'd0, 8'h77, 8'h11, 1'b1);
        strobe_once();
        wait_result("bp", -122880, -122880);
        for (int c = 1; c <= 20; c++) begin
            sample_strobe = (c == 2 || c == 10);
            @(negedge clk);
        end
        sample_strobe = 1'b0;
        check_eq("bp_valid", int'(sample_valid), 1);
        check_eq("bp_left", int'($signed(sample_left)), -122880);
        check_eq("bp_right", int'($signed(sample_right)), -122880);
        check_eq("bp_ovr", int'(overrun_count), 2);
        set_inputs(4'd4, 4'd8, 4'd2, 4'd1, 8'h30, 8'h21, 1'b1);
        sample_ready = 1'b1;
        sample_strobe = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
        sample_strobe = 1'b0;
        check_eq("bp_hs_ovr", int'(overrun_count), 2);
        wait_result("bp2", -212992, -241664);

        // Reset in ACCUM clears everything at once.
        handshake("bp2", -212992, -241664);
        strobe_once();
        @(negedge clk);
        check_eq("ra_busy", int'(busy), 1);
        reset = 1'b0;
        #1;
        check_eq("ra_valid", int'(sample_valid), 0);
        check_eq("ra_busy0", int'(busy), 0);
        check_eq("ra_left", int'($signed(sample_left)), 0);
        check_eq("ra_right", int'($signed(sample_right)), 0);
        check_eq("ra_ovr", int'(overrun_count), 0);

        // Release with strobe high, then hold it to saturate the counter.
        @(negedge clk);
        set_inputs(4'd15, 4'd15, 4'd15, 4'd15, 8'h77, 8'hFF, 1'b1);
        sample_strobe = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        check_eq("rel_busy", int'(busy), 1);
        check_eq("rel_ovr", int'(overrun_count), 0);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
        end
        sample_strobe = 1'b0;
        check_eq("sat_ovr", int'(overrun_count), 255);
        check_eq("sat_valid", int'(sample_valid), 1);
        check_eq("sat_left", int'($signed(sample_left)), 245760);
        handshake("sat", 245760, 245760);
        check_eq("sat_ovr_hold", int'(overrun_count), 255);

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
